mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage access engine that sits directly downstream of the EX/MEM pipeline register and upstream of MEM/WB.
- Turns the registered memory control, address, store data and destination register into a req/gnt/rvalid transaction on the data-memory bus.
- Stalls the front of the pipeline until the access completes, then presents load data and writeback control to MEM/WB.
- Handles misaligned and illegal accesses, and bus timeouts, by completing with an error flag instead of hanging the pipeline.

Parameters:
- DATA_W, 32, data and load/store width.
- ADDR_W, 32, byte address width.
- REG_W, 5, destination register index width.
- WB_W, 2, writeback control width.
- TIMEOUT, 16, maximum number of cycles spent in REQ+WAIT before the access is aborted (must be ≥2).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- mem_ctrl_i  in  2  bit1 = mem_read, bit0 = mem_write (from EX/MEM).
- wb_ctrl_i  in  WB_W  writeback control (from EX/MEM).
- addr_i  in  ADDR_W  ALU result / byte address.
- wdata_i  in  DATA_W  store data.
- rd_i  in  REG_W  destination register.
- stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  ADDR_W  word-aligned address.
- dmem_wdata_o  out  DATA_W  store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  DATA_W  read data.
- ld_data_o  out  DATA_W  load result to MEM/WB.
- alu_result_o  out  ADDR_W  addr_i pass-through.
- rd_o  out  REG_W  rd_i pass-through.
- wb_ctrl_o  out  WB_W  writeback control to MEM/WB.
- err_o  out  1  access error pulse.

Behaviour:
- Reset state: IDLE, counter = 0, captured address/data/we = 0, ld_data_o = 0, dmem_req_o = 0, err_o = 0.
- Reset asserted mid-transaction: drops dmem_req_o immediately and returns to IDLE; any late gnt/rvalid after reset release is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, mem_ctrl_i == 00: pure pass-through, stall_o = 0, no bus activity.
- IDLE, access request:
  - Aligned (addr_i[1:0] == 0) and exactly one of read/write set: capture addr, wdata and we, clear the counter, go to REQ.
  - mem_ctrl_i == 11, or misaligned: go to DONE with error pending; no bus access.
  - In both cases stall_o = 1 combinationally in that same IDLE cycle.
- REQ:
  - dmem_req_o = 1, with dmem_addr_o, dmem_we_o and dmem_wdata_o taken from the captured registers and held stable until gnt.
  - On gnt, write: go to DONE.
  - On gnt, read, with rvalid in the same cycle: capture rdata, go to DONE.
  - On gnt, read, without rvalid: go to WAIT.
- WAIT: dmem_req_o = 0; on rvalid, ld_data_o <= dmem_rdata_i and go to DONE.
- Timeout:
  - Counter increments every cycle spent in REQ or WAIT.
  - If it reaches TIMEOUT-1 with no completion event in that cycle, go to DONE with error; for a read, ld_data_o <= 0.
  - A completion event in the same cycle wins over the timeout.
- DONE:
  - stall_o = 0 and err_o = 1 if an error is pending.
  - Next state is always IDLE; the still-present EX/MEM inputs are not re-accepted.
  - Upstream advances on the edge that leaves DONE.
- stall_o = 1 in REQ and WAIT, and in IDLE when a new access is detected.
- wb_ctrl_o = wb_ctrl_i, except forced to 0 while stall_o = 1 (bubble) or in DONE with error (suppresses the faulty load's writeback).
- rd_o and alu_result_o are combinational pass-throughs.
- ld_data_o holds its value between loads.
- Store latency is 2 cycles minimum (IDLE detect, REQ with gnt); load latency is 2 cycles minimum, 3 with a separate rvalid.

Test Plan:
- Load, aligned: addr=0x0000_0010, gnt in the first REQ cycle, rvalid one cycle later with 0xDEAD_BEEF → stall_o high for 3 cycles (IDLE, REQ, WAIT), ld_data_o = 0xDEADBEEF in DONE, wb_ctrl_o = wb_ctrl_i, err_o = 0.
- Store: addr=0x24, wdata=0x1234_5678, gnt delayed 3 cycles → dmem_req_o/addr/wdata/we stable for 4 cycles, stall released in DONE, no rvalid needed.
- Misaligned load at addr=0x13 → dmem_req_o never asserted, DONE with err_o = 1 for 1 cycle, wb_ctrl_o = 0 in that cycle; mem_ctrl_i = 11 → identical response.
- Timeout, TIMEOUT=16: read granted, rvalid never arrives → DONE after 16 cycles in REQ+WAIT, err_o = 1, ld_data_o = 0.
- Same-cycle gnt and rvalid (0xA5A5_A5A5) → WAIT skipped, ld_data_o = 0xA5A5A5A5, stall for 2 cycles; back-to-back loads each start only from IDLE.
- rst_ni pulled low during WAIT → dmem_req_o = 0, stall_o = 0 and state IDLE immediately; an rvalid after release does not change ld_data_o (stays 0).

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory access engine with stall, error and timeout handling
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 5,
  parameter int WB_W    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        mem_ctrl_i,
  input  logic [WB_W-1:0]   wb_ctrl_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_W-1:0]  rd_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic [DATA_W-1:0] ld_data_o,
  output logic [ADDR_W-1:0] alu_result_o,
  output logic [REG_W-1:0]  rd_o,
  output logic [WB_W-1:0]   wb_ctrl_o,
  output logic              err_o
);

  // Counter only has to reach TIMEOUT-1; it is cleared on every entry to REQ.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-3:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   ld_data_q, ld_data_d;
  logic                err_q, err_d;

  logic mem_rd, mem_wr, access, illegal, timeout_hit;

  assign mem_rd      = mem_ctrl_i[1];
  assign mem_wr      = mem_ctrl_i[0];
  assign access      = mem_rd | mem_wr;
  // Both bits set, or a non-word address, cannot be issued on the bus.
  assign illegal     = (mem_rd & mem_wr) | (addr_i[1:0] != 2'b00);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State and captured-request registers; reset drops any bus request at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      ld_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      ld_data_q <= ld_data_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: issue, wait for grant/data, abort on timeout; completion beats timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    ld_data_d = ld_data_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (access) begin
          if (illegal) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d  = addr_i[ADDR_W-1:2];
            wdata_d = wdata_i;
            we_d    = mem_wr;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_gnt_i && we_q) begin
          state_d = S_DONE;
        end else if (dmem_gnt_i && dmem_rvalid_i) begin
          ld_data_d = dmem_rdata_i;
          state_d   = S_DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
          if (!we_q) ld_data_d = '0;
        end else if (dmem_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_rvalid_i) begin
          ld_data_d = dmem_rdata_i;
          state_d   = S_DONE;
        end else if (timeout_hit) begin
          err_d     = 1'b1;
          ld_data_d = '0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall_o      = (state_q == S_REQ) || (state_q == S_WAIT) ||
                        ((state_q == S_IDLE) && access);
  assign dmem_req_o   = (state_q == S_REQ);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = {addr_q, 2'b00};
  assign dmem_wdata_o = wdata_q;
  assign ld_data_o    = ld_data_q;
  assign err_o        = (state_q == S_DONE) && err_q;
  // Bubble while stalled, and kill the writeback of a faulted access.
  assign wb_ctrl_o    = (stall_o || err_o) ? '0 : wb_ctrl_i;
  assign alu_result_o = addr_i;
  assign rd_o         = rd_i;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;
  localparam int TIMEOUT = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  mem_ctrl_i;
  logic [1:0]  wb_ctrl_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_i;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] ld_data_o;
  logic [31:0] alu_result_o;
  logic [4:0]  rd_o;
  logic [1:0]  wb_ctrl_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_ld;

  mem_access_unit #(
    .DATA_W(32), .ADDR_W(32), .REG_W(5), .WB_W(2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mem_ctrl_i(mem_ctrl_i), .wb_ctrl_i(wb_ctrl_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i), .ld_data_o(ld_data_o), .alu_result_o(alu_result_o),
    .rd_o(rd_o), .wb_ctrl_o(wb_ctrl_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One EX/MEM access: the reference outcome is computed up front from the
  // grant/rvalid delays, then the bench plays bus slave and compares at DONE.
  task automatic run_txn(input logic [1:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gnt_dly,
                         input int rv_dly, input bit never_rv);
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [1:0]  wb;
    bit   illegal, exp_err, done, gnted, bus_bad, side_bad;
    int   need, cyc, exp_stall, exp_req, stall_n, req_n, post;
    rdata   = $urandom;
    rd      = 5'($urandom);
    wb      = 2'($urandom);
    illegal = (ctrl == 2'b11) || (ctrl != 2'b00 && addr[1:0] != 2'b00);
    exp_err = 1'b0;
    if (ctrl == 2'b00) begin
      exp_stall = 0; exp_req = 0;
    end else if (illegal) begin
      exp_stall = 1; exp_req = 0; exp_err = 1'b1;
    end else begin
      if (ctrl == 2'b01) need = gnt_dly + 1;
      else               need = never_rv ? TIMEOUT + 1 : gnt_dly + rv_dly + 1;
      if (need > TIMEOUT) begin exp_err = 1'b1; cyc = TIMEOUT; end
      else cyc = need;
      exp_stall = 1 + cyc;
      exp_req   = (gnt_dly + 1 < TIMEOUT) ? gnt_dly + 1 : TIMEOUT;
      if (ctrl == 2'b10) exp_ld = exp_err ? 32'h0 : rdata;
    end

    @(negedge clk_i);
    mem_ctrl_i = ctrl; addr_i = addr; wdata_i = wdata; rd_i = rd; wb_ctrl_i = wb;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    stall_n = 0; req_n = 0; post = 0; gnted = 0; bus_bad = 0; side_bad = 0; done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      #1;
      if (!stall_o) begin
        done = 1;
        check("stall_cycles", stall_n, exp_stall);
        check("req_cycles", req_n, exp_req);
        check("err_o", err_o, exp_err);
        check("wb_ctrl_o", wb_ctrl_o, exp_err ? 2'b00 : wb);
        check("ld_data_o", ld_data_o, exp_ld);
        check("req_in_done", dmem_req_o, 0);
        check("rd_o", rd_o, rd);
        check("alu_result_o", alu_result_o, addr);
        check("bus_stable", bus_bad, 0);
        check("stall_side", side_bad, 0);
      end else begin
        stall_n++;
        if (wb_ctrl_o != 2'b00 || err_o) side_bad = 1;
        if (dmem_req_o) begin
          if (dmem_addr_o != {addr[31:2], 2'b00} || dmem_we_o != ctrl[0] ||
              (ctrl[0] && dmem_wdata_o != wdata)) bus_bad = 1;
          if (req_n == gnt_dly) begin
            dmem_gnt_i = 1'b1; gnted = 1;
            if (ctrl[1] && rv_dly == 0 && !never_rv) begin
              dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
            end
          end
          req_n++;
        end else if (gnted) begin
          post++;
          if (ctrl[1] && !never_rv && post == rv_dly) begin
            dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
          end
        end
        @(negedge clk_i);
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
      end
    end
    if (!done) check("txn_finished", 0, 1);
  endtask

  initial begin
    rst_ni = 1'b0; mem_ctrl_i = 2'b00; wb_ctrl_i = 2'b11; addr_i = 32'h0; wdata_i = 32'h0;
    rd_i = 5'd0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    exp_ld = 32'h0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_req", dmem_req_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_err", err_o, 0);
    check("rst_ld", ld_data_o, 0);
    check("rst_addr", dmem_addr_o, 0);
    check("rst_we", dmem_we_o, 0);
    check("rst_wb", wb_ctrl_o, 2'b11);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed scenarios from the access rules.
    run_txn(2'b10, 32'h0000_0010, 32'h0, 0, 1, 0);            // aligned load, separate rvalid
    run_txn(2'b01, 32'h0000_0024, 32'h1234_5678, 3, 0, 0);    // store, delayed grant
    run_txn(2'b10, 32'h0000_0013, 32'h0, 0, 1, 0);            // misaligned load
    run_txn(2'b11, 32'h0000_0020, 32'h0, 0, 1, 0);            // both bits set
    run_txn(2'b10, 32'h0000_0030, 32'h0, 0, 0, 1);            // read timeout
    run_txn(2'b10, 32'h0000_0034, 32'h0, 0, 0, 0);            // same-cycle gnt+rvalid
    run_txn(2'b10, 32'h0000_0038, 32'h0, 0, 0, 0);            // back-to-back load
    run_txn(2'b10, 32'h0000_0040, 32'h0, 0, 15, 0);           // completes on last count
    run_txn(2'b10, 32'h0000_0044, 32'h0, 0, 16, 0);           // one cycle too late
    run_txn(2'b01, 32'h0000_0048, 32'hCAFE_F00D, 15, 0, 0);   // store granted on last count
    run_txn(2'b01, 32'h0000_004C, 32'hCAFE_F00D, 40, 0, 0);   // store never granted
    run_txn(2'b00, 32'h0000_0051, 32'h0, 0, 0, 0);            // no access

    for (int i = 0; i < 200; i++) begin
      logic [1:0]  c;
      logic [31:0] a;
      int g, r;
      c = 2'($urandom);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      g = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
      r = ($urandom_range(0, 9) == 0) ? 17 : $urandom_range(0, 4);
      run_txn(c, a, $urandom, g, r, $urandom_range(0, 9) == 0);
    end

    // Reset while waiting for read data; a late rvalid must be ignored.
    @(negedge clk_i);
    mem_ctrl_i = 2'b10; addr_i = 32'h0000_0060;
    @(negedge clk_i);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("wait_stall", stall_o, 1);
    rst_ni = 1'b0; mem_ctrl_i = 2'b00;
    #1;
    check("midrst_req", dmem_req_o, 0);
    check("midrst_stall", stall_o, 0);
    check("midrst_ld", ld_data_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_AAAA;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    #1;
    check("late_rvalid_ld", ld_data_o, 0);
    check("late_rvalid_stall", stall_o, 0);
    check("late_rvalid_err", err_o, 0);
    exp_ld = 32'h0;
    run_txn(2'b10, 32'h0000_0064, 32'h0, 1, 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
